// File: rtl/gen_s_pkg.sv
// Shared definitions for the gen_s read responder: FSM encoding, response
// codes, beat/page geometry and the burst error check.
package gen_s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;

  localparam int BEAT_BYTES = 64;
  localparam int PAGE_BYTES = 4096;

  // A burst is bad if its start is not beat aligned or it runs past the end
  // of its 4KB page. Only the in-page offset matters, so 12 address bits do.
  function automatic logic burst_err(input logic [11:0] addr_lo, input logic [7:0] len);
    logic [15:0] end_off;
    end_off = {4'd0, addr_lo} + (({8'd0, len} + 16'd1) << 6);
    return (addr_lo[5:0] != 6'd0) || (end_off > 16'(PAGE_BYTES));
  endfunction

endpackage

// File: rtl/gen_s_req_fifo.sv
// Synchronous request FIFO; full/empty come from a registered occupancy count
// so a same-cycle pop never makes room for a same-cycle push at full.
module gen_s_req_fifo #(
  parameter int W     = 73,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers and occupancy; power-of-2 depth lets the pointers wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gen_s_rd_responder.sv
// Read responder for the gen_m* master interface: queues read bursts and
// returns mlen+1 beats of an address-derived pattern after RD_LAT cycles.
module gen_s_rd_responder
  import gen_s_pkg::*;
#(
  parameter int AXI_DW   = 512,
  parameter int AXI_AW   = 64,
  parameter int AXI_MIDW = 1,
  parameter int Q_DEPTH  = 4,
  parameter int RD_LAT   = 4
) (
  input  logic                axi_clk,
  input  logic                axi_rst,
  input  logic [AXI_AW-1:0]   gen_s_maddr,
  input  logic [7:0]          gen_s_mlen,
  input  logic [AXI_MIDW-1:0] gen_s_mid,
  input  logic                gen_s_mread,
  input  logic                gen_s_mwrite,
  input  logic                gen_s_mready,
  output logic                gen_s_saccept,
  output logic [AXI_DW-1:0]   gen_s_sdata,
  output logic [AXI_MIDW-1:0] gen_s_sid,
  output logic                gen_s_slast,
  output logic [2:0]          gen_s_sresp,
  output logic                gen_s_svalid,
  output logic [31:0]         o_req_cnt,
  output logic [31:0]         o_beat_cnt,
  output logic                o_wr_err
);

  localparam int REQ_W    = AXI_AW + 8 + AXI_MIDW;
  localparam int LANES    = AXI_DW / 64;
  localparam int LAT_W    = $clog2(RD_LAT + 1);
  // The pop cycle counts as the first latency cycle, hence the -2.
  localparam int LAT_LOAD = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  logic                q_full, q_empty, push, pop, beat_xfer;
  logic [REQ_W-1:0]    q_rdata;
  logic [AXI_AW-1:0]   q_addr;
  logic [7:0]          q_len;
  logic [AXI_MIDW-1:0] q_id;

  state_t              state, state_nxt;
  logic [AXI_AW-1:0]   b_addr, beat_addr;
  logic [7:0]          b_len, beat_idx;
  logic [AXI_MIDW-1:0] b_id;
  logic                b_err;
  logic [LAT_W-1:0]    lat_cnt;
  logic [LANES-1:0][63:0] lane_data;

  assign gen_s_saccept = !q_full && !axi_rst;
  assign push          = gen_s_mread && gen_s_saccept && !gen_s_mwrite;
  assign beat_xfer     = gen_s_svalid && gen_s_mready;
  assign {q_addr, q_len, q_id} = q_rdata;

  gen_s_req_fifo #(.W(REQ_W), .DEPTH(Q_DEPTH)) u_req_fifo (
    .clk   (axi_clk),
    .rst   (axi_rst),
    .push  (push),
    .wdata ({gen_s_maddr, gen_s_mlen, gen_s_mid}),
    .pop   (pop),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

  // Burst sequencing: pop a request, wait out the latency, stream the beats.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: if (!q_empty) begin
        pop = 1'b1;
        if (RD_LAT == 1) state_nxt = ST_BURST;
        else             state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (lat_cnt == '0) state_nxt = ST_BURST;
      ST_BURST: if (gen_s_mready && (beat_idx == b_len)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Burst context: captured on pop, beat index advances per handshake.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      b_addr   <= '0;
      b_len    <= '0;
      b_id     <= '0;
      b_err    <= 1'b0;
      beat_idx <= '0;
      lat_cnt  <= '0;
    end else if (pop) begin
      b_addr   <= q_addr;
      b_len    <= q_len;
      b_id     <= q_id;
      b_err    <= burst_err(q_addr[11:0], q_len);
      beat_idx <= '0;
      lat_cnt  <= LAT_W'(LAT_LOAD);
    end else begin
      if (state == ST_WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
      if (beat_xfer) beat_idx <= beat_idx + 1'b1;
    end
  end

  // Statistics and the sticky unsupported-write flag.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      o_req_cnt  <= '0;
      o_beat_cnt <= '0;
      o_wr_err   <= 1'b0;
    end else begin
      if (push)         o_req_cnt  <= o_req_cnt + 32'd1;
      if (beat_xfer)    o_beat_cnt <= o_beat_cnt + 32'd1;
      if (gen_s_mwrite) o_wr_err   <= 1'b1;
    end
  end

  // Pattern: lane i carries the byte address of its 8-byte word in the beat.
  assign beat_addr = b_addr + AXI_AW'({beat_idx, 6'd0});
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_data[g] = 64'(beat_addr + AXI_AW'(8 * g));
  end

  // Outputs are functions of registered burst state, so they hold under mready=0.
  assign gen_s_svalid = (state == ST_BURST);
  assign gen_s_sdata  = (gen_s_svalid && !b_err) ? AXI_DW'(lane_data) : '0;
  assign gen_s_slast  = gen_s_svalid && (beat_idx == b_len);
  assign gen_s_sresp  = (gen_s_svalid && b_err) ? RESP_SLVERR : RESP_OKAY;
  assign gen_s_sid    = gen_s_svalid ? b_id : '0;

endmodule

// File: tb/tb_gen_s_rd_responder.sv
// Directed bench for gen_s_rd_responder with a beat scoreboard.
module tb_gen_s_rd_responder;

  localparam int RD_LAT = 4;

  logic         clk = 1'b0, rst = 1'b1;
  logic [63:0]  maddr = '0;
  logic [7:0]   mlen = '0;
  logic         mid = 1'b0, mread = 1'b0, mwrite = 1'b0, mready = 1'b1;
  logic         saccept, sid, slast, svalid, wr_err;
  logic [511:0] sdata;
  logic [2:0]   sresp;
  logic [31:0]  req_cnt, beat_cnt;

  gen_s_rd_responder #(.RD_LAT(RD_LAT)) dut (
    .axi_clk(clk), .axi_rst(rst),
    .gen_s_maddr(maddr), .gen_s_mlen(mlen), .gen_s_mid(mid),
    .gen_s_mread(mread), .gen_s_mwrite(mwrite), .gen_s_mready(mready),
    .gen_s_saccept(saccept), .gen_s_sdata(sdata), .gen_s_sid(sid),
    .gen_s_slast(slast), .gen_s_sresp(sresp), .gen_s_svalid(svalid),
    .o_req_cnt(req_cnt), .o_beat_cnt(beat_cnt), .o_wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic [2:0]   resp;
    logic         id;
  } beat_t;

  beat_t sb[$];
  int compared = 0, mismatched = 0, beats_seen = 0, cyc = 0, acc_cyc = 0;
  int n_req = 0, n_beats = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [519:0] obs, input logic [519:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Model of one accepted burst: pushes every expected beat.
  task automatic expect_burst(input logic [63:0] a, input logic [7:0] len, input logic id);
    bit err;
    err = (a[5:0] != 6'd0) || ((int'(a[11:0]) + 64 * (int'(len) + 1)) > 4096);
    for (int b = 0; b <= int'(len); b++) begin
      beat_t t;
      logic [63:0] ba;
      ba = a + 64'(64 * b);
      for (int i = 0; i < 8; i++) t.data[64*i +: 64] = err ? 64'd0 : ba + 64'(8 * i);
      t.last = (b == int'(len));
      t.resp = err ? 3'b010 : 3'b000;
      t.id   = id;
      sb.push_back(t);
    end
    n_req++;
    n_beats += int'(len) + 1;
  endtask

  task automatic send(input logic [63:0] a, input logic [7:0] len, input logic id);
    maddr = a; mlen = len; mid = id; mread = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (saccept) begin
        expect_burst(a, len, id);
        tick();
        acc_cyc = cyc;
        mread = 1'b0;
        return;
      end
      tick();
    end
    mread = 1'b0;
    compared++; mismatched++;
    $error("FAIL send_timeout observed=no_accept expected=accept addr=%0h", a);
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && sb.size() != 0; k++) tick();
    chk("drain_empty", 520'(sb.size()), 520'd0);
    tick(); tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; mread = 1'b0; mwrite = 1'b0;
    tick(); tick();
    chk("rst_ctl", {saccept, svalid, slast, sresp, sid, wr_err}, '0);
    chk("rst_data", sdata, '0);
    chk("rst_cnt", {req_cnt, beat_cnt}, '0);
    sb.delete(); n_req = 0; n_beats = 0;
    rst = 1'b0;
    tick();
  endtask

  // Beat monitor: scoreboard compare on handshake, stability check under stall.
  logic         hold_v = 1'b0;
  logic [519:0] hold_s;
  always @(negedge clk) begin : mon
    beat_t t;
    if (rst) hold_v = 1'b0;
    else begin
      if (hold_v) chk("hold_stable", {svalid, slast, sresp, sid, sdata}, hold_s);
      hold_v = svalid && !mready;
      hold_s = {svalid, slast, sresp, sid, sdata};
      if (svalid && mready) begin
        beats_seen++;
        if (sb.size() == 0) begin
          compared++; mismatched++;
          $error("FAIL unexpected_beat observed=beat expected=none sdata=%0h", sdata[63:0]);
        end else begin
          t = sb.pop_front();
          chk("beat_data", sdata, t.data);
          chk("beat_ctl", {slast, sresp, sid}, {t.last, t.resp, t.id});
        end
      end
    end
  end

  initial begin : stim
    int b0;
    do_reset();

    // T1 single burst and first-beat latency
    mready = 1'b1;
    send(64'h1000, 8'd3, 1'b1);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (svalid) break;
    end
    chk("t1_latency", 520'(cyc - acc_cyc), 520'(RD_LAT));
    tick();
    drain();
    chk("t1_cnt", {req_cnt, beat_cnt}, {32'd1, 32'd4});

    // T2 backpressure
    do_reset();
    send(64'h1000, 8'd3, 1'b1);
    for (int k = 0; k < 300 && sb.size() != 0; k++) begin
      mready = ~mready;
      tick();
    end
    mready = 1'b1;
    drain();
    chk("t2_beat_cnt", 520'(beat_cnt), 520'd4);

    // T3 queue full: burst 0 is held in the engine by mready=0, so four more
    // fill the queue and the sixth request is refused.
    mready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      maddr = 64'h2000 + 64'(i) * 64'h100; mlen = 8'd1; mid = i[0]; mread = 1'b1;
      @(negedge clk);
      chk("t3_saccept", 520'(saccept), 520'(i < 5));
      if (saccept) expect_burst(maddr, mlen, mid);
      tick();
    end
    mread = 1'b0;
    tick();
    chk("t3_req_cnt", 520'(req_cnt), 520'(n_req));
    mready = 1'b1;
    send(64'h2500, 8'd1, 1'b1);
    drain();
    chk("t3_cnt", {req_cnt, beat_cnt}, {32'(n_req), 32'(n_beats)});

    // T4 error bursts and the exact-page-end non-error case
    send(64'h0FC0, 8'd1, 1'b0);
    send(64'h1004, 8'd0, 1'b1);
    send(64'h0F80, 8'd1, 1'b1);
    drain();
    chk("t4_cnt", {req_cnt, beat_cnt}, {32'(n_req), 32'(n_beats)});

    // T5 write rejected, address wrap
    maddr = 64'h5000; mlen = 8'd0; mread = 1'b1; mwrite = 1'b1;
    @(negedge clk);
    chk("t5_saccept", 520'(saccept), 520'd1);
    tick();
    mread = 1'b0; mwrite = 1'b0;
    tick(); tick();
    chk("t5_wr_err", {wr_err, req_cnt}, {1'b1, 32'(n_req)});
    send(64'hFFFF_FFFF_FFFF_FFC0, 8'd0, 1'b1);
    drain();
    chk("t5_wr_err_sticky", 520'(wr_err), 520'd1);

    // T6 reset during beat 2 of an 8-beat burst
    do_reset();
    send(64'h3000, 8'd7, 1'b0);
    b0 = beats_seen;
    for (int k = 0; k < 100 && beats_seen < b0 + 1; k++) tick();
    rst = 1'b1;
    tick();
    chk("t6_svalid", {svalid, beat_cnt, req_cnt}, '0);
    sb.delete(); n_req = 0; n_beats = 0;
    rst = 1'b0;
    tick();
    chk("t6_saccept", 520'(saccept), 520'd1);
    send(64'h3000, 8'd1, 1'b1);
    drain();
    chk("t6_cnt", {req_cnt, beat_cnt}, {32'd1, 32'd2});

    chk("sb_final", 520'(sb.size()), 520'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
